// File: rtl/instruction_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit_if
// Purpose : groups the fetch unit's control, ROM and IR handshake signals.
// Modports:
//   master - the fetch unit: drives programSelect/address to the ROM, the
//            IR handshake outputs (irValid/ir/irPc) and status
//            (busy/halted/fault/fetchCount); receives start/programSelectIn,
//            the ROM word, irReady and the redirect request.
//   slave  - the surrounding system (ROM, decode/execute, control).
// ----------------------------------------------------------------------------
interface instruction_fetch_unit_if #(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 16
);
    logic                   start;
    logic [1:0]             programSelectIn;
    logic [1:0]             programSelect;
    logic [ADDR_WIDTH-1:0]  address;
    logic [INSTR_WIDTH-1:0] instruction;
    logic                   irValid;
    logic                   irReady;
    logic [INSTR_WIDTH-1:0] ir;
    logic [ADDR_WIDTH-1:0]  irPc;
    logic                   redirectValid;
    logic [ADDR_WIDTH-1:0]  redirectTarget;
    logic                   busy;
    logic                   halted;
    logic                   fault;
    logic [15:0]            fetchCount;

    modport master (
        input  start, programSelectIn, instruction, irReady,
               redirectValid, redirectTarget,
        output programSelect, address, irValid, ir, irPc,
               busy, halted, fault, fetchCount
    );

    modport slave (
        output start, programSelectIn, instruction, irReady,
               redirectValid, redirectTarget,
        input  programSelect, address, irValid, ir, irPc,
               busy, halted, fault, fetchCount
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
// Purpose : fetch stage. Owns the PC, addresses a combinational instruction
//           ROM and latches each returned word into a one-entry instruction
//           register (IR) with a valid/ready handshake towards decode/execute.
//           Stops at the HALT opcode, faults on running off the end of the
//           ROM or on an out-of-range redirect target.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset
//           bus   - instruction_fetch_unit_if.master (start/program select,
//                   ROM address/data, IR handshake, redirect, status)
// Options : define IFU_PERF_COUNT_EN to build the saturating fetchCount
//           counter; otherwise fetchCount is constant zero.
// ----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter int         ADDR_WIDTH  = 8,
    parameter int         INSTR_WIDTH = 16,
    parameter int         MEM_DEPTH   = 128,
    parameter logic [3:0] HALT_OPCODE = 4'b1110
) (
    input  logic                     clk,
    input  logic                     rst_n,
    instruction_fetch_unit_if.master bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] LAST_PC   = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    logic [1:0]             r_state,     r_state_next;
    logic [ADDR_WIDTH-1:0]  r_pc,        r_pc_next;
    logic [1:0]             r_prog_sel,  r_prog_sel_next;
    logic                   r_ir_valid,  r_ir_valid_next;
    logic [INSTR_WIDTH-1:0] r_ir,        r_ir_next;
    logic [ADDR_WIDTH-1:0]  r_ir_pc,     r_ir_pc_next;
    logic                   r_busy,      r_busy_next;
    logic                   r_halted,    r_halted_next;
    logic                   r_fault,     r_fault_next;

    logic w_slot_free;
    logic w_is_halt;
    logic w_target_oob;
    logic w_start_ok;
    logic w_redirect;
    logic w_fetch;

    // The IR can take a new word when it is empty or being consumed now.
    assign w_slot_free  = !r_ir_valid || bus.irReady;
    assign w_is_halt    = (bus.instruction[INSTR_WIDTH-1 -: 4] == HALT_OPCODE);
    // Zero-extend so targets at or beyond the depth are caught even when
    // MEM_DEPTH equals 2**ADDR_WIDTH.
    assign w_target_oob = ({1'b0, bus.redirectTarget} >= DEPTH_EXT);
    assign w_start_ok   = bus.start && (r_state == S_IDLE || r_state == S_HALTED);
    assign w_redirect   = bus.redirectValid && (r_state == S_FETCH || r_state == S_DRAIN);
    assign w_fetch      = (r_state == S_FETCH) && w_slot_free && !w_redirect;

    always_comb begin
        r_state_next    = r_state;
        r_pc_next       = r_pc;
        r_prog_sel_next = r_prog_sel;
        r_ir_valid_next = r_ir_valid;
        r_ir_next       = r_ir;
        r_ir_pc_next    = r_ir_pc;
        r_halted_next   = r_halted;
        r_fault_next    = r_fault;

        if (w_start_ok) begin
            r_state_next    = S_FETCH;
            r_pc_next       = '0;
            r_prog_sel_next = bus.programSelectIn;
            r_ir_valid_next = 1'b0;
            r_halted_next   = 1'b0;
            r_fault_next    = 1'b0;
        end else if (w_redirect) begin
            // Redirect wins over fetch and drain; the IR is flushed even if
            // downstream is accepting it this cycle.
            r_ir_valid_next = 1'b0;
            if (w_target_oob) begin
                // PC is left at its last legal value; the empty IR lets
                // DRAIN finish on the following edge.
                r_fault_next = 1'b1;
                r_state_next = S_DRAIN;
            end else begin
                r_pc_next    = bus.redirectTarget;
                r_fault_next = 1'b0;
                r_state_next = S_FETCH;
            end
        end else if (w_fetch) begin
            r_ir_next       = bus.instruction;
            r_ir_pc_next    = r_pc;
            r_ir_valid_next = 1'b1;
            if (w_is_halt) begin
                r_state_next = S_DRAIN;
            end else if (r_pc == LAST_PC) begin
                // Word is still delivered; the PC never leaves the ROM.
                r_fault_next = 1'b1;
                r_state_next = S_DRAIN;
            end else begin
                r_pc_next = r_pc + 1'b1;
            end
        end else if (r_state == S_DRAIN && w_slot_free) begin
            r_ir_valid_next = 1'b0;
            r_halted_next   = 1'b1;
            r_state_next    = S_HALTED;
        end

        r_busy_next = (r_state_next == S_FETCH) || (r_state_next == S_DRAIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_prog_sel <= '0;
            r_ir_valid <= 1'b0;
            r_ir       <= '0;
            r_ir_pc    <= '0;
            r_busy     <= 1'b0;
            r_halted   <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= r_state_next;
            r_pc       <= r_pc_next;
            r_prog_sel <= r_prog_sel_next;
            r_ir_valid <= r_ir_valid_next;
            r_ir       <= r_ir_next;
            r_ir_pc    <= r_ir_pc_next;
            r_busy     <= r_busy_next;
            r_halted   <= r_halted_next;
            r_fault    <= r_fault_next;
        end
    end

`ifdef IFU_PERF_COUNT_EN
    // Counts every IR load, including words later flushed by a redirect.
    logic [15:0] r_fetch_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_count <= 16'h0000;
        end else if (w_start_ok) begin
            r_fetch_count <= 16'h0000;
        end else if (w_fetch && r_fetch_count != 16'hFFFF) begin
            r_fetch_count <= r_fetch_count + 16'h0001;
        end
    end

    assign bus.fetchCount = r_fetch_count;
`else
    assign bus.fetchCount = 16'h0000;
`endif

    assign bus.programSelect = r_prog_sel;
    assign bus.address       = r_pc;
    assign bus.irValid       = r_ir_valid;
    assign bus.ir            = r_ir;
    assign bus.irPc          = r_ir_pc;
    assign bus.busy          = r_busy;
    assign bus.halted        = r_halted;
    assign bus.fault         = r_fault;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Self-checking bench for instruction_fetch_unit. A four-program ROM lives in
// the bench; the expected delivery order of each run is computed straight
// from the ROM contents (walk from the start PC until HALT or the last word).
// ----------------------------------------------------------------------------
module tb_instruction_fetch_unit;
    localparam int MEM_DEPTH = 128;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    logic [15:0] rom [4][256];

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.instruction = rom[bus.programSelect][bus.address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        w = 16'($urandom);
        if (w[15:12] == 4'hE) w[15:12] = 4'h0;
        return w;
    endfunction

    task automatic fill_prog1(input int halt_pos);
        logic [15:0] w;
        for (int i = 0; i < 256; i++) rom[1][i] = (i < MEM_DEPTH) ? rand_word() : 16'h0;
        w = 16'($urandom);
        w[15:12] = 4'hE;
        rom[1][halt_pos] = w;
    endtask

    task automatic fill_roms();
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < 256; i++) rom[p][i] = 16'h0000;
        for (int i = 0; i < MEM_DEPTH; i++) rom[0][i] = rand_word();
        fill_prog1(20);
        rom[2][0] = 16'h0102; rom[2][1] = 16'h2F10; rom[2][2] = 16'h0203;
        rom[2][3] = 16'h2F20; rom[2][4] = 16'h4F21; rom[2][5] = 16'hE000;
        for (int i = 0; i < 9; i++) rom[3][i] = rand_word();
        rom[3][9] = 16'hE123;
    endtask

    function automatic logic [15:0] exp_count(input int n);
`ifdef IFU_PERF_COUNT_EN
        return 16'(n);
`else
        return 16'(n - n);
`endif
    endfunction

    task automatic do_start(input int ps);
        logic [1:0] sel;
        sel = 2'(ps);
        bus.irReady = 1'b0;
        bus.start = 1'b1;
        bus.programSelectIn = sel;
        @(negedge clk);
        bus.start = 1'b0;
        tests++;
        if (bus.address !== 8'd0 || bus.programSelect !== sel || bus.irValid !== 1'b0 ||
            bus.busy !== 1'b1 || bus.halted !== 1'b0 || bus.fault !== 1'b0 ||
            bus.fetchCount !== 16'h0) begin
            fails++;
            $display("FAIL start_p%0d: got addr=%0d psel=%0d v=%b busy=%b halt=%b flt=%b cnt=%0d required addr=0 psel=%0d v=0 busy=1 halt=0 flt=0 cnt=0",
                     ps, bus.address, bus.programSelect, bus.irValid, bus.busy, bus.halted,
                     bus.fault, bus.fetchCount, sel);
        end else
            $display("[TB] start program %0d ok", ps);
    endtask

    // mode 0: ready always; mode 1: pattern 1,0,0,1; mode 2: random ready.
    task automatic consume_run(input int ps, input int start_pc, input int mode,
                               input int extra, input string name);
        logic [15:0] exp_word[$];
        logic [7:0]  exp_pc[$];
        logic [15:0] w;
        logic [15:0] prev_ir;
        logic [7:0]  prev_irpc, prev_addr, last_pc;
        bit          exp_fault, prev_stall, just_done, finished, ready;
        int          pc, total, consumed, cyc;

        exp_fault = 1'b0;
        pc = start_pc;
        while (1) begin
            w = rom[ps][pc];
            exp_word.push_back(w);
            exp_pc.push_back(8'(pc));
            if (w[15:12] == 4'hE) break;
            if (pc == MEM_DEPTH - 1) begin exp_fault = 1'b1; break; end
            pc++;
        end
        last_pc = 8'(pc);
        total = exp_word.size();
        consumed = 0; cyc = 0;
        prev_stall = 0; just_done = 0; finished = 0;
        prev_ir = '0; prev_irpc = '0; prev_addr = '0;

        while (cyc < 2000) begin
            if (just_done) begin
                tests++;
                if (bus.halted !== 1'b1 || bus.busy !== 1'b0 || bus.irValid !== 1'b0) begin
                    fails++;
                    $display("FAIL %s_halted_rise: got halted=%b busy=%b v=%b required halted=1 busy=0 v=0",
                             name, bus.halted, bus.busy, bus.irValid);
                end
                finished = 1;
                break;
            end
            tests++;
            if (bus.address > last_pc || bus.halted !== 1'b0) begin
                fails++;
                $display("FAIL %s_run_state: got addr=%0d halted=%b required addr<=%0d halted=0",
                         name, bus.address, bus.halted, last_pc);
            end
            if (prev_stall && bus.irValid) begin
                tests++;
                if (bus.ir !== prev_ir || bus.irPc !== prev_irpc || bus.address !== prev_addr) begin
                    fails++;
                    $display("FAIL %s_stall_hold: got ir=%h irPc=%0d addr=%0d required ir=%h irPc=%0d addr=%0d",
                             name, bus.ir, bus.irPc, bus.address, prev_ir, prev_irpc, prev_addr);
                end
            end
            case (mode)
                0: ready = 1'b1;
                1: ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: ready = 1'($urandom_range(0, 1));
            endcase
            bus.irReady = ready;
            if (bus.irValid && ready) begin
                tests++;
                if (bus.ir !== exp_word[consumed] || bus.irPc !== exp_pc[consumed]) begin
                    fails++;
                    $display("FAIL %s_word%0d: got ir=%h irPc=%0d required ir=%h irPc=%0d",
                             name, consumed, bus.ir, bus.irPc, exp_word[consumed], exp_pc[consumed]);
                end else
                    $display("[TB] %s consume ir=%h irPc=%0d", name, bus.ir, bus.irPc);
                consumed++;
                if (consumed == total) just_done = 1;
            end
            prev_stall = bus.irValid && !ready;
            prev_ir = bus.ir; prev_irpc = bus.irPc; prev_addr = bus.address;
            @(negedge clk);
            cyc++;
        end
        bus.irReady = 1'b0;
        tests++;
        if (!finished) begin
            fails++;
            $display("FAIL %s_timeout: got %0d of %0d words required all words then halted",
                     name, consumed, total);
        end
        tests++;
        if (bus.fault !== exp_fault || bus.fetchCount !== exp_count(extra + total)) begin
            fails++;
            $display("FAIL %s_final: got fault=%b cnt=%0d required fault=%b cnt=%0d",
                     name, bus.fault, bus.fetchCount, exp_fault, exp_count(extra + total));
        end
    endtask

    task automatic check_reset_values(input string name);
        tests++;
        if (bus.address !== 8'd0 || bus.programSelect !== 2'd0 || bus.irValid !== 1'b0 ||
            bus.ir !== 16'h0 || bus.irPc !== 8'd0 || bus.busy !== 1'b0 ||
            bus.halted !== 1'b0 || bus.fault !== 1'b0 || bus.fetchCount !== 16'h0) begin
            fails++;
            $display("FAIL %s: got addr=%0d psel=%0d v=%b ir=%h irPc=%0d busy=%b halt=%b flt=%b cnt=%0d required all zero",
                     name, bus.address, bus.programSelect, bus.irValid, bus.ir, bus.irPc,
                     bus.busy, bus.halted, bus.fault, bus.fetchCount);
        end else
            $display("[TB] %s ok", name);
    endtask

    task automatic wait_irpc1(input string name);
        int n;
        n = 0;
        bus.irReady = 1'b1;
        while (!(bus.irValid && bus.irPc == 8'd1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 20) begin
            fails++;
            $display("FAIL %s_wait: got no irPc=1 within 20 cycles required irPc=1 valid", name);
        end
    endtask

    task automatic test_reset();
        check_reset_values("reset_asserted");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("reset_idle_hold");
    endtask

    task automatic test_program2();
        do_start(2);
        consume_run(2, 0, 0, 0, "prog2");
    endtask

    task automatic test_backpressure();
        do_start(3);
        consume_run(3, 0, 1, 0, "prog3_bp");
    endtask

    task automatic test_start_ignored();
        do_start(3);
        bus.start = 1'b1;
        bus.programSelectIn = 2'd1;
        bus.irReady = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        tests++;
        if (bus.programSelect !== 2'd3 || bus.irValid !== 1'b1 || bus.ir !== rom[3][0] ||
            bus.irPc !== 8'd0 || bus.address !== 8'd1) begin
            fails++;
            $display("FAIL start_ignored: got psel=%0d v=%b ir=%h irPc=%0d addr=%0d required psel=3 v=1 ir=%h irPc=0 addr=1",
                     bus.programSelect, bus.irValid, bus.ir, bus.irPc, bus.address, rom[3][0]);
        end
        consume_run(3, 0, 0, 0, "start_ignored");
    endtask

    task automatic test_redirect();
        fill_prog1(20);
        do_start(1);
        wait_irpc1("redirect");
        bus.redirectValid = 1'b1;
        bus.redirectTarget = 8'd3;
        @(negedge clk);
        bus.redirectValid = 1'b0;
        tests++;
        if (bus.irValid !== 1'b0 || bus.address !== 8'd3 || bus.busy !== 1'b1 || bus.fault !== 1'b0) begin
            fails++;
            $display("FAIL redirect_flush: got v=%b addr=%0d busy=%b flt=%b required v=0 addr=3 busy=1 flt=0",
                     bus.irValid, bus.address, bus.busy, bus.fault);
        end
        @(negedge clk);
        tests++;
        if (bus.irValid !== 1'b1 || bus.ir !== rom[1][3] || bus.irPc !== 8'd3) begin
            fails++;
            $display("FAIL redirect_target: got v=%b ir=%h irPc=%0d required v=1 ir=%h irPc=3",
                     bus.irValid, bus.ir, bus.irPc, rom[1][3]);
        end
        consume_run(1, 3, 2, 2, "redirect");
    endtask

    task automatic test_bad_redirect();
        do_start(1);
        wait_irpc1("bad_redirect");
        bus.redirectValid = 1'b1;
        bus.redirectTarget = 8'd200;
        @(negedge clk);
        bus.redirectValid = 1'b0;
        tests++;
        if (bus.irValid !== 1'b0 || bus.fault !== 1'b1 || bus.busy !== 1'b1 || bus.halted !== 1'b0) begin
            fails++;
            $display("FAIL bad_redirect_m: got v=%b flt=%b busy=%b halt=%b required v=0 flt=1 busy=1 halt=0",
                     bus.irValid, bus.fault, bus.busy, bus.halted);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests++;
            if (bus.halted !== 1'b1 || bus.fault !== 1'b1 || bus.busy !== 1'b0 ||
                bus.irValid !== 1'b0 || bus.fetchCount !== exp_count(2)) begin
                fails++;
                $display("FAIL bad_redirect_hold%0d: got halt=%b flt=%b busy=%b v=%b cnt=%0d required halt=1 flt=1 busy=0 v=0 cnt=%0d",
                         k, bus.halted, bus.fault, bus.busy, bus.irValid, bus.fetchCount, exp_count(2));
            end
        end
    endtask

    task automatic test_no_halt();
        do_start(0);
        consume_run(0, 0, 0, 0, "prog0_fault");
    endtask

    task automatic test_restart_from_halted();
        do_start(2);
        consume_run(2, 0, 2, 0, "restart");
    endtask

    task automatic test_reset_midfetch();
        int n;
        fill_prog1(20);
        do_start(1);
        bus.irReady = 1'b1;
        n = 0;
        while (bus.address != 8'd4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 20) begin
            fails++;
            $display("FAIL reset_mid_wait: got addr=%0d required addr=4", bus.address);
        end
        #2 rst_n = 1'b0;
        #1 check_reset_values("reset_midfetch");
        @(negedge clk);
        rst_n = 1'b1;
        do_start(2);
        consume_run(2, 0, 1, 0, "after_reset");
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            fill_prog1(int'($urandom_range(5, 40)));
            do_start(1);
            consume_run(1, 0, 2, 0, "random");
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.programSelectIn = 2'd0;
        bus.irReady = 1'b0;
        bus.redirectValid = 1'b0;
        bus.redirectTarget = 8'd0;
        fill_roms();
        repeat (3) @(negedge clk);

        test_reset();
        test_program2();
        test_backpressure();
        test_start_ignored();
        test_redirect();
        test_bad_redirect();
        test_no_halt();
        test_restart_from_halted();
        test_reset_midfetch();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
